// File: rtl/d_transfer_seq.sv
// d_transfer_seq: multi-cycle sequencer for D-format load/store (LDUR/STUR
// family). It walks IDLE -> ADDR -> MEM -> [WB] -> [BASE] and drives one
// datapath control word per cycle. It covers B/H/W/X sizes, sign-extending
// loads, pre/post-index base writeback, a mem_ready wait with timeout, and
// alignment and illegal-encoding faults.
//
// Ports:
//   clock, reset_n   rising-edge clock, synchronous active-low reset
//   start, I         instruction valid and word (sampled in IDLE only)
//   addr_lo          address bits [2:0], used on the first MEM cycle
//   mem_ready        memory access completes this cycle (MEM only)
//   ContW            {NState, K, WR, IL, En_ALU, En_B, En_Addr, En_PC,
//                     En_PC_Addr, B_SEL, PC_SEL, W_En, O_En, CS, En_Stat,
//                     PS[1:0], FS[4:0], BA, AA, DA}
//   mem_size         captured I[31:30]
//   ld_signed        captured load is sign-extending
//   busy, done       non-IDLE; one-cycle pulse on the final cycle
//   fault, fault_code  sticky fault until the next accepted start
module d_transfer_seq #(
  parameter int K_W         = 64,
  parameter int WAIT_MAX    = 15,
  parameter int ALIGN_CHECK = 1,
  localparam int CW_W       = K_W + 36
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [31:0]     I,
  input  logic [2:0]      addr_lo,
  input  logic            mem_ready,
  output logic [CW_W-1:0] ContW,
  output logic [1:0]      mem_size,
  output logic            ld_signed,
  output logic            busy,
  output logic            done,
  output logic            fault,
  output logic [1:0]      fault_code
);

  localparam logic [4:0] FS_ADD     = 5'b01000;
  localparam logic [1:0] FC_ALIGN   = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;
  localparam logic [1:0] FC_ILLEGAL = 2'b11;
  localparam bit         ALIGN_ON   = (ALIGN_CHECK != 0);

  typedef enum logic [2:0] {IDLE, ADDR, MEM, WB, BASE, FAULT} seqStateT;

  // Only the instruction fields the sequence uses are kept.
  typedef struct packed {
    logic [1:0] size;
    logic [1:0] opc;
    logic [8:0] imm9;
    logic [1:0] idx;
    logic [4:0] rn;
    logic [4:0] rt;
  } instT;

  typedef struct packed {
    logic           nState;
    logic [K_W-1:0] k;
    logic           wr;
    logic           il;
    logic           enAlu;
    logic           enB;
    logic           enAddr;
    logic           enPc;
    logic           enPcAddr;
    logic           bSel;
    logic           pcSel;
    logic           wEn;
    logic           oEn;
    logic           cs;
    logic           enStat;
    logic [1:0]     ps;
    logic [4:0]     fs;
    logic [4:0]     ba;
    logic [4:0]     aa;
    logic [4:0]     da;
  } cwT;

  seqStateT       state, nxt;
  instT           inst;
  logic [7:0]     waitCnt;
  cwT             cw;
  logic           fin, faultSet, misaligned, isStore, indexed;
  logic [1:0]     faultCodeNxt;
  logic [2:0]     alignMask;
  logic [K_W-1:0] simm;

  // Opcode-class bits and the unused I[21] carry no meaning here.
  logic unusedBits;
  assign unusedBits = ^{I[29:24], I[21]};

  assign simm    = {{(K_W-9){inst.imm9[8]}}, inst.imm9};
  assign isStore = (inst.opc == 2'b00);
  assign indexed = (inst.idx != 2'b00);

  always_comb begin
    unique case (inst.size)
      2'b00:   alignMask = 3'b000;
      2'b01:   alignMask = 3'b001;
      2'b10:   alignMask = 3'b011;
      default: alignMask = 3'b111;
    endcase
  end

  assign misaligned = ALIGN_ON && ((addr_lo & alignMask) != 3'b000);

  always_comb begin
    nxt          = state;
    cw           = '0;
    fin          = 1'b0;
    done         = 1'b0;
    faultSet     = 1'b0;
    faultCodeNxt = 2'b00;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (I[23:22] == 2'b11 || I[11:10] == 2'b10) begin
            nxt          = FAULT;
            faultSet     = 1'b1;
            faultCodeNxt = FC_ILLEGAL;
          end else begin
            nxt = ADDR;
          end
        end
      end
      ADDR: begin
        cw.aa     = inst.rn;
        cw.bSel   = 1'b1;
        cw.enAlu  = 1'b1;
        cw.enAddr = 1'b1;
        cw.fs     = FS_ADD;
        // Post-index accesses memory at the unmodified base.
        cw.k      = (inst.idx == 2'b01) ? '0 : simm;
        nxt       = MEM;
      end
      MEM: begin
        cw.cs = 1'b1;
        if (isStore) begin
          cw.ba  = inst.rt;
          cw.enB = 1'b1;
          cw.wEn = 1'b1;
        end else begin
          cw.oEn = 1'b1;
        end
        // waitCnt==0 marks the first MEM cycle; misalignment beats ready.
        if (waitCnt == 8'd0 && misaligned) begin
          cw.cs        = 1'b0;
          cw.wEn       = 1'b0;
          cw.oEn       = 1'b0;
          nxt          = FAULT;
          faultSet     = 1'b1;
          faultCodeNxt = FC_ALIGN;
        end else if (mem_ready) begin
          if (!isStore)     nxt = WB;
          else if (indexed) nxt = BASE;
          else              fin = 1'b1;
        end else if (waitCnt == 8'(WAIT_MAX - 1)) begin
          nxt          = FAULT;
          faultSet     = 1'b1;
          faultCodeNxt = FC_TIMEOUT;
        end
      end
      WB: begin
        cw.wr  = 1'b1;
        cw.da  = inst.rt;
        cw.oEn = 1'b1;
        cw.cs  = 1'b1;
        if (indexed) nxt = BASE;
        else         fin = 1'b1;
      end
      BASE: begin
        cw.aa    = inst.rn;
        cw.k     = simm;
        cw.bSel  = 1'b1;
        cw.enAlu = 1'b1;
        cw.fs    = FS_ADD;
        cw.wr    = 1'b1;
        cw.da    = inst.rn;
        fin      = 1'b1;
      end
      FAULT: begin
        cw.enStat = 1'b1;
        nxt       = IDLE;
      end
      default: nxt = IDLE;
    endcase
    if (fin) begin
      cw.ps = 2'b01;
      done  = 1'b1;
      nxt   = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      inst       <= '0;
      waitCnt    <= '0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else begin
      state   <= nxt;
      // Counts not-ready MEM cycles; cleared whenever MEM is left.
      waitCnt <= (state == MEM && nxt == MEM) ? waitCnt + 8'd1 : 8'd0;
      if (state == IDLE && start) begin
        inst       <= {I[31:30], I[23:22], I[20:12], I[11:10], I[9:5], I[4:0]};
        fault      <= 1'b0;
        fault_code <= 2'b00;
      end
      if (faultSet) begin
        fault      <= 1'b1;
        fault_code <= faultCodeNxt;
      end
    end
  end

  assign ContW     = cw;
  assign mem_size  = inst.size;
  assign ld_signed = (inst.opc == 2'b10);
  assign busy      = (state != IDLE);

endmodule
